// File: rtl/cpu_mem_arb_pkg.sv
// Shared types and constants for the CPU data-memory arbiter.
package cpu_mem_arb_pkg;

    // Owner of the read currently in flight towards the memory.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_EX,
        OWN_ACCEL
    } owner_t;

    // Requester indices, also the round-robin order cpu -> accel -> ex.
    localparam logic [1:0] REQ_CPU   = 2'd0;
    localparam logic [1:0] REQ_ACCEL = 2'd1;
    localparam logic [1:0] REQ_EX    = 2'd2;
    localparam int         NUM_REQ   = 3;

    // Default wait budget before a non-CPU requester outranks the CPU.
    localparam int DEF_STARVE_LIMIT = 8;

    // Requester following idx in round-robin order.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == REQ_EX) ? REQ_CPU : idx + 2'd1;
    endfunction

endpackage

// File: rtl/cpu_mem_arb_age.sv
// Saturating wait-age counter for one non-CPU requester.
// starved rises once the requester has waited STARVE_LIMIT cycles.
module cpu_mem_arb_age
    import cpu_mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int AGE_W        = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic gnt,
    output logic starved
);

    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(STARVE_LIMIT);
    localparam logic [AGE_W-1:0] AGE_ONE   = AGE_W'(1);

    logic [AGE_W-1:0] age;

    // Count waiting cycles, clear on grant or withdrawn request, saturate at the limit.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else if (!req || gnt) begin
            age <= '0;
        end else if (age != AGE_LIMIT) begin
            age <= age + AGE_ONE;
        end
    end

    assign starved = (age == AGE_LIMIT);

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Single-port data-memory arbiter for CPU MEM stage, external host and
// accelerator writeback. One access per cycle; read data is tagged back
// to its owner one cycle after the grant.
// Build option: MEMARB_RR_EN selects round-robin cpu->accel->ex instead of
// fixed priority with starvation aging.
module cpu_mem_arbiter
    import cpu_mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int AGE_W        = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    input  logic              ex_req,
    input  logic              ex_wr,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              ex_gnt,
    output logic              ex_rvalid,
    input  logic              accel_req,
    input  logic [ADDR_W-1:0] accel_addr,
    input  logic [DATA_W-1:0] accel_wdata,
    output logic              accel_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wrt_data,
    output logic              mem_wrt_en,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rd_data
);

    logic              any_gnt;
    logic [1:0]        sel;
    logic [2:0]        gnt_vec;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_wr;
    owner_t            next_owner;
    owner_t            owner_q;
    logic [DATA_W-1:0] rd_hold;
    logic              issue;

`ifdef MEMARB_RR_EN
    logic [1:0] rr_ptr;
    logic [1:0] cand;
    logic [2:0] req_vec;

    assign req_vec = {ex_req, accel_req, cpu_req};

    // Pick the first requester at or after the round-robin pointer.
    always_comb begin
        any_gnt = 1'b0;
        sel     = REQ_CPU;
        cand    = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_gnt && req_vec[cand]) begin
                any_gnt = 1'b1;
                sel     = cand;
            end
            cand = rr_next(cand);
        end
    end

    // Move the pointer past the last granted requester; hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= REQ_CPU;
        end else if (any_gnt) begin
            rr_ptr <= rr_next(sel);
        end
    end
`else
    logic accel_starved;
    logic ex_starved;

    cpu_mem_arb_age #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .AGE_W        (AGE_W)
    ) u_age_accel (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (accel_req),
        .gnt     (gnt_vec[REQ_ACCEL]),
        .starved (accel_starved)
    );

    cpu_mem_arb_age #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .AGE_W        (AGE_W)
    ) u_age_ex (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (ex_req),
        .gnt     (gnt_vec[REQ_EX]),
        .starved (ex_starved)
    );

    // Fixed priority: starved accel > starved ex > cpu > accel > ex.
    always_comb begin
        any_gnt = 1'b1;
        sel     = REQ_CPU;
        if (accel_req && accel_starved) begin
            sel = REQ_ACCEL;
        end else if (ex_req && ex_starved) begin
            sel = REQ_EX;
        end else if (cpu_req) begin
            sel = REQ_CPU;
        end else if (accel_req) begin
            sel = REQ_ACCEL;
        end else if (ex_req) begin
            sel = REQ_EX;
        end else begin
            any_gnt = 1'b0;
        end
    end
`endif

    // Route the winning requester onto the memory access and note the read owner.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_vec    = 3'b000;
        acc_addr   = '0;
        acc_wdata  = '0;
        acc_wr     = 1'b0;
        next_owner = OWN_NONE;
        if (any_gnt) begin
            gnt_vec[sel] = 1'b1;
            case (sel)
                REQ_CPU: begin
                    acc_addr   = cpu_addr;
                    acc_wdata  = cpu_wdata;
                    acc_wr     = cpu_wr;
                    next_owner = cpu_wr ? OWN_NONE : OWN_CPU;
                end
                REQ_ACCEL: begin
                    acc_addr  = accel_addr;
                    acc_wdata = accel_wdata;
                    acc_wr    = 1'b1;
                end
                default: begin
                    acc_addr   = ex_addr;
                    acc_wdata  = ex_wdata;
                    acc_wr     = ex_wr;
                    next_owner = ex_wr ? OWN_NONE : OWN_EX;
                end
            endcase
        end
    end

    // Outputs are forced quiet while reset is held.
    assign issue        = any_gnt & rst_n;
    assign cpu_gnt      = gnt_vec[REQ_CPU] & rst_n;
    assign accel_gnt    = gnt_vec[REQ_ACCEL] & rst_n;
    assign ex_gnt       = gnt_vec[REQ_EX] & rst_n;
    assign cpu_stall    = cpu_req & ~gnt_vec[REQ_CPU] & rst_n;
    assign mem_addr     = issue ? acc_addr : '0;
    assign mem_wrt_data = (issue && acc_wr) ? acc_wdata : '0;
    assign mem_wrt_en   = issue & acc_wr;
    assign mem_rd_en    = issue & ~acc_wr;

    // Track who owns the read returning next cycle and keep the last returned word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
            rd_hold <= '0;
        end else begin
            owner_q <= next_owner;
            if (owner_q != OWN_NONE) begin
                rd_hold <= mem_rd_data;
            end
        end
    end

    assign cpu_rvalid = (owner_q == OWN_CPU);
    assign ex_rvalid  = (owner_q == OWN_EX);
    assign rd_data    = (owner_q != OWN_NONE) ? mem_rd_data : rd_hold;

endmodule
